instr_sequencer: RTL and testbench

Fetch/decode/execute controller for the simple processor. Sequences the program counter, instruction register load, ALU and accumulator write. It issues instruction-memory requests and waits for a valid handshake. It resolves jumps and conditional branches using the ALU zero flag, and halts on HALT. It sits between instruction memory, the program counter and the ALU/accumulator datapath.

---
 rtl/seq_pkg.sv | 39 +++
 rtl/instr_decoder.sv | 55 +++++
 rtl/instr_sequencer.sv | 118 +++++++++++
 tb/tb_instr_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, ALU operations,
// opcodes and the default field widths.
package seq_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int OPC_W_DEF   = 4;
  localparam int INSTR_W_DEF = OPC_W_DEF + ADDR_W_DEF;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5
  } alu_op_t;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_LDI  = 4'h1;
  localparam logic [3:0] OPC_ADD  = 4'h2;
  localparam logic [3:0] OPC_SUB  = 4'h3;
  localparam logic [3:0] OPC_AND  = 4'h4;
  localparam logic [3:0] OPC_OR   = 4'h5;
  localparam logic [3:0] OPC_XOR  = 4'h6;
  localparam logic [3:0] OPC_JMP  = 4'h7;
  localparam logic [3:0] OPC_JZ   = 4'h8;
  localparam logic [3:0] OPC_JNZ  = 4'h9;
  localparam logic [3:0] OPC_HALT = 4'hF;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder producing the execute-phase control bundle.
// The caller is responsible for gating every output with the EXECUTE state.
module instr_decoder
  import seq_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic [2:0]       alu_op,
  output logic             acc_we,
  output logic             branch,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             is_halt,
  output logic             is_illegal
);

  always_comb begin
    alu_op     = ALU_PASS;
    acc_we     = 1'b0;
    branch     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OPC_W'(OPC_NOP): pc_inc = 1'b1;
      OPC_W'(OPC_LDI): begin acc_we = 1'b1; pc_inc = 1'b1; alu_op = ALU_PASS; end
      OPC_W'(OPC_ADD): begin acc_we = 1'b1; pc_inc = 1'b1; alu_op = ALU_ADD;  end
      OPC_W'(OPC_SUB): begin acc_we = 1'b1; pc_inc = 1'b1; alu_op = ALU_SUB;  end
      OPC_W'(OPC_AND): begin acc_we = 1'b1; pc_inc = 1'b1; alu_op = ALU_AND;  end
      OPC_W'(OPC_OR):  begin acc_we = 1'b1; pc_inc = 1'b1; alu_op = ALU_OR;   end
      OPC_W'(OPC_XOR): begin acc_we = 1'b1; pc_inc = 1'b1; alu_op = ALU_XOR;  end
      OPC_W'(OPC_JMP): begin branch = 1'b1; pc_load = 1'b1; end
      OPC_W'(OPC_JZ): begin
        branch  = 1'b1;
        pc_load = zero;
        pc_inc  = ~zero;
      end
      OPC_W'(OPC_JNZ): begin
        branch  = 1'b1;
        pc_load = ~zero;
        pc_inc  = zero;
      end
      OPC_W'(OPC_HALT): is_halt = 1'b1;
      // Unassigned opcodes behave as NOP but are flagged.
      default: begin
        is_illegal = 1'b1;
        pc_inc     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: drives instruction fetch, IR load, PC
// update, ALU operation and accumulator write for the simple processor.
//
// state   | meaning
// IDLE    | waiting for start, all strobes off
// FETCH   | imem_req high, IR captured when imem_valid
// DECODE  | one quiet cycle, HALT opcode diverts to HALT
// EXECUTE | decoded strobes issued, instruction retired
// HALT    | sticky stop, only reset leaves
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OPC_W  = OPC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    imem_valid,
  input  logic [OPC_W+ADDR_W-1:0] instr,
  input  logic                    zero,
  output logic                    imem_req,
  output logic                    ir_load,
  output logic                    pc_inc,
  output logic                    pc_load,
  output logic [ADDR_W-1:0]       pc_target,
  output logic [2:0]              alu_op,
  output logic [ADDR_W-1:0]       operand,
  output logic                    acc_we,
  output logic                    halted,
  output logic                    illegal,
  output logic [CNT_W-1:0]        retired,
  output logic [2:0]              state
);

  localparam int INSTR_W = OPC_W + ADDR_W;

  state_t             cur_state, nxt_state;
  logic [INSTR_W-1:0] ir;
  logic [OPC_W-1:0]   opcode;

  logic [2:0] dec_alu_op;
  logic       dec_acc_we, dec_branch, dec_pc_inc, dec_pc_load;
  logic       dec_halt, dec_illegal;
  logic       in_execute;

  assign opcode     = ir[INSTR_W-1:ADDR_W];
  assign operand    = ir[ADDR_W-1:0];
  assign pc_target  = ir[ADDR_W-1:0];
  assign state      = cur_state;
  assign halted     = (cur_state == ST_HALT);
  assign in_execute = (cur_state == ST_EXECUTE);

  instr_decoder #(
    .OPC_W (OPC_W)
  ) u_decoder (
    .opcode     (opcode),
    .zero       (zero),
    .alu_op     (dec_alu_op),
    .acc_we     (dec_acc_we),
    .branch     (dec_branch),
    .pc_inc     (dec_pc_inc),
    .pc_load    (dec_pc_load),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  always_comb begin
    nxt_state = cur_state;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    acc_we    = 1'b0;
    alu_op    = ALU_PASS;
    case (cur_state)
      ST_IDLE: begin
        if (start) nxt_state = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_load   = 1'b1;
          nxt_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        nxt_state = dec_halt ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        alu_op    = dec_alu_op;
        acc_we    = dec_acc_we;
        pc_inc    = dec_pc_inc;
        // Only branch-class opcodes are ever allowed to load the PC.
        pc_load   = dec_pc_load & dec_branch;
        nxt_state = ST_FETCH;
      end
      ST_HALT: nxt_state = ST_HALT;
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= ST_IDLE;
      ir        <= '0;
      illegal   <= 1'b0;
      retired   <= '0;
    end else begin
      cur_state <= nxt_state;
      if (ir_load) ir <= instr;
      if (in_execute && dec_illegal) illegal <= 1'b1;
      if (in_execute) retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a per-cycle vector table for the main
// program flow plus hand-written sequences for mid-execute reset and retired wrap.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       imem_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       zero = 1'b0;
  logic       imem_req, ir_load, pc_inc, pc_load, acc_we, halted, illegal;
  logic [3:0] pc_target, operand;
  logic [2:0] alu_op, state;
  logic [7:0] retired;

  int checks = 0;
  int errors = 0;

  instr_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_valid (imem_valid),
    .instr      (instr),
    .zero       (zero),
    .imem_req   (imem_req),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .alu_op     (alu_op),
    .operand    (operand),
    .acc_we     (acc_we),
    .halted     (halted),
    .illegal    (illegal),
    .retired    (retired),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       start;
    logic       valid;
    logic [7:0] instr;
    logic       zero;
    logic [2:0] st;
    logic       req;
    logic       irl;
    logic       inc;
    logic       ld;
    logic       we;
    logic [2:0] op;
    logic [3:0] opd;
    logic       hlt;
    logic       ill;
    logic [7:0] ret;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] m_opd = 4'h0;
  logic [7:0] m_ret = 8'h00;
  logic       m_ill = 1'b0;

  function automatic vec_t mk(logic s, logic v, logic [7:0] in, logic z, logic [2:0] st,
                              logic req, logic irl, logic inc, logic ld, logic we,
                              logic [2:0] op, logic [3:0] opd, logic hlt, logic ill,
                              logic [7:0] ret);
    vec_t r;
    r.start = s; r.valid = v; r.instr = in; r.zero = z; r.st = st;
    r.req = req; r.irl = irl; r.inc = inc; r.ld = ld; r.we = we;
    r.op = op; r.opd = opd; r.hlt = hlt; r.ill = ill; r.ret = ret;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Three cycles of one instruction with valid data on the first FETCH cycle.
  task automatic add_instr(logic [7:0] in, logic z, logic we, logic [2:0] op,
                           logic inc, logic ld, logic ill_op);
    vecs.push_back(mk(0, 1, in, 0, 3'd1, 1, 1, 0, 0, 0, 3'd0, m_opd, 0, m_ill, m_ret));
    m_opd = in[3:0];
    vecs.push_back(mk(0, 0, 8'h00, 0, 3'd2, 0, 0, 0, 0, 0, 3'd0, m_opd, 0, m_ill, m_ret));
    vecs.push_back(mk(0, 0, 8'h00, z, 3'd3, 0, 0, inc, ld, we, op, m_opd, 0, m_ill, m_ret));
    m_ret = m_ret + 8'd1;
    if (ill_op) m_ill = 1'b1;
  endtask

  task automatic check_vec(int idx, vec_t v);
    chk($sformatf("v%0d_state", idx),    32'(state),     32'(v.st));
    chk($sformatf("v%0d_imem_req", idx), 32'(imem_req),  32'(v.req));
    chk($sformatf("v%0d_ir_load", idx),  32'(ir_load),   32'(v.irl));
    chk($sformatf("v%0d_pc_inc", idx),   32'(pc_inc),    32'(v.inc));
    chk($sformatf("v%0d_pc_load", idx),  32'(pc_load),   32'(v.ld));
    chk($sformatf("v%0d_acc_we", idx),   32'(acc_we),    32'(v.we));
    chk($sformatf("v%0d_operand", idx),  32'(operand),   32'(v.opd));
    chk($sformatf("v%0d_pc_target", idx), 32'(pc_target), 32'(v.opd));
    chk($sformatf("v%0d_halted", idx),   32'(halted),    32'(v.hlt));
    chk($sformatf("v%0d_illegal", idx),  32'(illegal),   32'(v.ill));
    chk($sformatf("v%0d_retired", idx),  32'(retired),   32'(v.ret));
    if (v.we) chk($sformatf("v%0d_alu_op", idx), 32'(alu_op), 32'(v.op));
  endtask

  initial begin
    // Idle after reset
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 4'h0, 0, 0, 8'd0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 4'h0, 0, 0, 8'd0));
    // Straight-line LDI 5, ADD 3
    add_instr(8'h15, 0, 1, 3'd0, 1, 0, 0);
    add_instr(8'h23, 0, 1, 3'd1, 1, 0, 0);
    // Fetch stall of four cycles, then JZ 0xA taken
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 8'h00, 0, 3'd1, 1, 0, 0, 0, 0, 3'd0, m_opd, 0, 0, m_ret));
    add_instr(8'h8A, 1, 0, 3'd0, 0, 1, 0);
    add_instr(8'h8A, 0, 0, 3'd0, 1, 0, 0);
    add_instr(8'h95, 0, 0, 3'd0, 0, 1, 0);
    add_instr(8'h96, 1, 0, 3'd0, 1, 0, 0);
    // Remaining ALU ops, NOP and JMP
    add_instr(8'h34, 0, 1, 3'd2, 1, 0, 0);
    add_instr(8'h4F, 1, 1, 3'd3, 1, 0, 0);
    add_instr(8'h5E, 0, 1, 3'd4, 1, 0, 0);
    add_instr(8'h6D, 0, 1, 3'd5, 1, 0, 0);
    add_instr(8'h0B, 1, 0, 3'd0, 1, 0, 0);
    add_instr(8'h72, 0, 0, 3'd0, 0, 1, 0);
    // Illegal opcode then HALT
    add_instr(8'hC7, 0, 0, 3'd0, 1, 0, 1);
    vecs.push_back(mk(0, 1, 8'hF0, 0, 3'd1, 1, 1, 0, 0, 0, 3'd0, m_opd, 0, m_ill, m_ret));
    vecs.push_back(mk(0, 0, 8'h00, 0, 3'd2, 0, 0, 0, 0, 0, 3'd0, 4'h0, 0, m_ill, m_ret));
    vecs.push_back(mk(0, 0, 8'h00, 0, 3'd4, 0, 0, 0, 0, 0, 3'd0, 4'h0, 1, m_ill, m_ret));
    vecs.push_back(mk(1, 0, 8'h00, 1, 3'd4, 0, 0, 0, 0, 0, 3'd0, 4'h0, 1, m_ill, m_ret));
    vecs.push_back(mk(1, 1, 8'h15, 0, 3'd4, 0, 0, 0, 0, 0, 3'd0, 4'h0, 1, m_ill, m_ret));
    vecs.push_back(mk(0, 1, 8'h23, 0, 3'd4, 0, 0, 0, 0, 0, 3'd0, 4'h0, 1, m_ill, m_ret));

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state",    32'(state),    32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_alu_op",   32'(alu_op),   32'd0);
    chk("rst_operand",  32'(operand),  32'd0);
    chk("rst_retired",  32'(retired),  32'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      start      = vecs[i].start;
      imem_valid = vecs[i].valid;
      instr      = vecs[i].instr;
      zero       = vecs[i].zero;
      #1;
      check_vec(i, vecs[i]);
    end

    // Reset leaves HALT and clears the sticky flags
    @(negedge clk);
    reset = 1'b0; start = 1'b0; imem_valid = 1'b0; zero = 1'b0;
    #1;
    chk("hrst_state",   32'(state),   32'd0);
    chk("hrst_halted",  32'(halted),  32'd0);
    chk("hrst_illegal", 32'(illegal), 32'd0);
    chk("hrst_retired", 32'(retired), 32'd0);
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; imem_valid = 1'b1; instr = 8'h13;
    #1 chk("r1_ir_load", 32'(ir_load), 32'd1);
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    #1 chk("r1_exec_we", 32'(acc_we), 32'd1);
    @(negedge clk);
    imem_valid = 1'b1; instr = 8'h29;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("r2_exec_we",  32'(acc_we),  32'd1);
    chk("r2_exec_op",  32'(alu_op),  32'd1);
    chk("r2_retired",  32'(retired), 32'd1);
    // Reset in the middle of EXECUTE of ADD
    #2 reset = 1'b0;
    #1;
    chk("mrst_state",    32'(state),    32'd0);
    chk("mrst_acc_we",   32'(acc_we),   32'd0);
    chk("mrst_pc_inc",   32'(pc_inc),   32'd0);
    chk("mrst_pc_load",  32'(pc_load),  32'd0);
    chk("mrst_imem_req", 32'(imem_req), 32'd0);
    chk("mrst_alu_op",   32'(alu_op),   32'd0);
    chk("mrst_operand",  32'(operand),  32'd0);
    chk("mrst_retired",  32'(retired),  32'd0);
    chk("mrst_illegal",  32'(illegal),  32'd0);

    // Restart after release
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    #1 chk("rs_idle", 32'(state), 32'd0);
    @(negedge clk);
    start = 1'b0; imem_valid = 1'b1; instr = 8'h11;
    #1;
    chk("rs_fetch_state", 32'(state),   32'd1);
    chk("rs_ir_load",     32'(ir_load), 32'd1);
    @(negedge clk);
    instr = 8'h00;
    #1;
    chk("rs_decode_state", 32'(state),   32'd2);
    chk("rs_operand",      32'(operand), 32'd1);
    @(negedge clk);
    #1;
    chk("rs_exec_we",  32'(acc_we), 32'd1);
    chk("rs_exec_inc", 32'(pc_inc), 32'd1);
    @(negedge clk);
    #1 chk("rs_retired", 32'(retired), 32'd1);

    // 255 more NOPs wrap retired from 255 back to 0
    repeat (765) @(negedge clk);
    #1;
    chk("wrap_retired", 32'(retired), 32'd0);
    chk("wrap_state",   32'(state),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
